icache: RTL
===========

// Module: icache
// PURPOSE
//  Instruction-side responder for the datapath/cache interface: answers datapath fetches
//  (imemREN/imemaddr -> ihit/imemload) from a direct-mapped, one-word-per-block array.
//  Misses become single-word reads to the memory controller (iREN/iaddr -> iwait/iload).
//  Sits between the pipelined datapath and the memory controller; datapath stalls while ihit=0.
// PARAMETERS
//  SETS   16   number of direct-mapped frames; power of two, >=2
//  IDX_W  4    $clog2(SETS); index = imemaddr[IDX_W+1:2], tag = imemaddr[31:IDX_W+2]
// PORTS
//  CLK        in   1      clock; all state updates on posedge
//  nRST       in   1      asynchronous active-low reset
//  imemREN    in   1      datapath fetch request
//  imemaddr   in   32     fetch byte address; bits [1:0] ignored
//  flush      in   1      invalidate every frame (e.g. on halt or self-modifying code)
//  ihit       out  1      fetch satisfied this cycle; imemload valid
//  imemload   out  32     instruction word to datapath
//  iREN       out  1      read request to memory controller
//  iaddr      out  32     word-aligned miss address to memory controller
//  iwait      in   1      memory busy; iload valid when iREN=1 and iwait=0
//  iload      in   32     fill word from memory controller
// BEHAVIOUR
//  Storage: per frame valid(1), tag(32-IDX_W-2), data(32). Only valid resets.
//  Reset: state=IDLE, all valid=0, miss_addr=0. Outputs: ihit=0, imemload=0, iREN=0, iaddr=0.
//    Reset mid-FETCH aborts the fetch. No frame is written.
//  hit = imemREN & valid[idx] & (tag[idx]==imemaddr tag) & (state==IDLE) & !flush.
//  ihit = hit, combinational, zero-latency. imemload = hit ? data[idx] : 32'h0.
//  FSM, two states:
//   IDLE : iREN=0, iaddr=0.
//          imemREN & !hit & !flush -> latch miss_addr={imemaddr[31:2],2'b00}; go to FETCH.
//          imemREN=0 -> stay in IDLE; no request.
//   FETCH: iREN=1, iaddr=miss_addr, ihit=0 regardless of imemaddr.
//          iwait=1 -> stay in FETCH.
//          iwait=0 -> write data=iload, tag and valid=1 into frame miss_addr[IDX_W+1:2]; go to IDLE.
//  Fill-to-hit latency: the fill cycle does not assert ihit. The next IDLE cycle hits if imemaddr
//    still maps to the filled block. Minimum miss penalty = memory latency + 1 cycle.
//  imemaddr changing during FETCH (branch redirect): the fetch completes into miss_addr's frame.
//    The new address is looked up after the return to IDLE; no abort.
//  Conflict: a fill overwrites the frame unconditionally; no write-back (read-only cache).
//  flush=1: next cycle all valid=0 and state=IDLE; ihit=0 during the flush cycle.
//    flush with completing fill (FETCH, iwait=0) in the same cycle: flush wins, frame stays invalid.
//    flush held high: ihit stays 0; no new misses are started.
//  imemREN=0 during FETCH: the fetch still completes (no abort); no new request in the next IDLE.
// TESTING
//  1 Reset, imemREN=1, imemaddr=0x0000_0040, iwait=1 for 3 cycles, then iload=0x2001_0005
//    -> iREN=1 with iaddr=0x40 for 4 cycles; ihit=1 with imemload=0x2001_0005 on the next cycle.
//  2 Re-fetch 0x0000_0040 after fill -> ihit=1 same cycle, iREN stays 0.
//  3 Conflict: fill 0x40, then fetch 0x0000_0080 (same index 0, different tag)
//    -> miss, iaddr=0x80; then refetch 0x40 misses again.
//  4 Redirect: miss on 0x44; during FETCH change imemaddr to 0x100, complete fill with 0xDEAD_BEEF
//    -> frame 1 valid with tag of 0x44; 0x100 then misses with iaddr=0x100.
//  5 flush asserted in the fill cycle of 0x48 -> ihit=0; a later fetch of 0x48 misses again.
//    Fill 4 frames, pulse flush -> every address misses.
//  6 nRST deasserted mid-FETCH (async) -> iREN=0, iaddr=0 immediately; all lookups miss after release.

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-block, read-only instruction cache.
//   Datapath side : imemREN/imemaddr in, ihit/imemload out (zero-latency hit).
//   Memory side   : iREN/iaddr out, iwait/iload in (single-word fill on miss).
//   Control       : flush invalidates every frame; nRST is asynchronous active-low.
// Parameters: SETS frames (power of two, >=2), IDX_W = $clog2(SETS).
module icache #(
   parameter int unsigned SETS  = 16,
   parameter int unsigned IDX_W = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   input  logic        flush,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
);

   localparam int unsigned TAG_W = 32 - IDX_W - 2;

   typedef enum logic {StIdle, StFetch} state_t;

   state_t            state, next_state;
   logic [SETS-1:0]   valid;
   logic [TAG_W-1:0]  tags  [SETS];
   logic [31:0]       data  [SETS];
   logic [31:2]       miss_word;

   logic [IDX_W-1:0]  idx, fill_idx;
   logic [TAG_W-1:0]  tag_in;
   logic              hit, fill, start_miss;
   logic              unused_addr;

   // Byte offset is meaningless for word fetches.
   assign unused_addr = ^imemaddr[1:0];

   assign idx      = imemaddr[IDX_W+1:2];
   assign tag_in   = imemaddr[31:IDX_W+2];
   assign fill_idx = miss_word[IDX_W+1:2];

   assign hit = imemREN & valid[idx] & (tags[idx] == tag_in) & (state == StIdle) & ~flush;
   assign start_miss = (state == StIdle) & imemREN & ~hit & ~flush;
   // A fill coinciding with flush is dropped so the frame stays invalid.
   assign fill = (state == StFetch) & ~iwait & ~flush;

   assign ihit     = hit;
   assign imemload = hit ? data[idx] : 32'h0;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= StIdle;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      iREN       = 1'b0;
      iaddr      = 32'h0;
      unique case (state)
         StIdle: begin
            if (start_miss) next_state = StFetch;
         end
         StFetch: begin
            iREN  = 1'b1;
            iaddr = {miss_word, 2'b00};
            if (!iwait) next_state = StIdle;
         end
         default: next_state = StIdle;
      endcase
      if (flush) next_state = StIdle;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         miss_word <= '0;
      end else if (start_miss) begin
         miss_word <= imemaddr[31:2];
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid <= '0;
      end else if (flush) begin
         valid <= '0;
      end else if (fill) begin
         valid[fill_idx] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; valid alone qualifies them.
   always_ff @(posedge CLK) begin
      if (fill) begin
         tags[fill_idx] <= miss_word[31:IDX_W+2];
         data[fill_idx] <= iload;
      end
   end

endmodule
